// File: rtl/RV32I_definitions.sv
// ----------------------------------------------------------------------------
// RV32I_definitions
// Shared widths and the packed ID->EX payload carried by id_ex_pipeline.
// The payload groups every field that is copied straight from decode into
// the EX register; the operands are kept outside it because they are
// bypass-corrected and refreshed independently while EX is stalled.
// ----------------------------------------------------------------------------
package RV32I_definitions;

    localparam int REG_DATA_WIDTH     = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int CTRL_WIDTH         = 16;

    typedef struct packed {
        logic [REG_DATA_WIDTH-1:0]     pc;
        logic [REGFILE_ADDR_WIDTH-1:0] rs1_addr;
        logic [REGFILE_ADDR_WIDTH-1:0] rs2_addr;
        logic [REGFILE_ADDR_WIDTH-1:0] rd_addr;
        logic [REG_DATA_WIDTH-1:0]     imm;
        logic [CTRL_WIDTH-1:0]         ctrl;
        logic                          is_load;
    } id_ex_payload_t;

endpackage

// File: rtl/id_hazard_unit.sv
// ----------------------------------------------------------------------------
// id_hazard_unit
// Purely combinational. Produces the write-through bypassed operands for the
// instruction in decode and flags a load-use hazard against the load in EX.
//
// Ports
//   id_valid_i            decode holds a valid instruction
//   rs1/rs2_addr_i        operand specifiers in decode
//   uses_rs1/rs2_i        instruction really reads that operand
//   rs1/rs2_data_i        register file read data
//   ex_valid_i            EX holds a real instruction
//   ex_is_load_i          instruction in EX is a load
//   ex_rd_addr_i          destination of the instruction in EX
//   wb_wr_en_i/addr_i/data_i  writeback port, same as the register file sees
//   hazard_o              load-use hazard
//   byp_rs1/rs2_o         bypass-corrected operands
// ----------------------------------------------------------------------------
module id_hazard_unit
    import RV32I_definitions::*;
#(
    parameter int DW = REG_DATA_WIDTH,
    parameter int AW = REGFILE_ADDR_WIDTH
) (
    input  logic          id_valid_i,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    input  logic          uses_rs1_i,
    input  logic          uses_rs2_i,
    input  logic [DW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    input  logic          ex_valid_i,
    input  logic          ex_is_load_i,
    input  logic [AW-1:0] ex_rd_addr_i,
    input  logic          wb_wr_en_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    output logic          hazard_o,
    output logic [DW-1:0] byp_rs1_o,
    output logic [DW-1:0] byp_rs2_o
);

    logic [1:0][AW-1:0] rs_addr;
    logic [1:0][DW-1:0] rs_data;
    logic [1:0][DW-1:0] byp;
    logic [1:0]         uses;
    logic [1:0]         dep;

    assign rs_addr = {rs2_addr_i, rs1_addr_i};
    assign rs_data = {rs2_data_i, rs1_data_i};
    assign uses    = {uses_rs2_i, uses_rs1_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            // x0 is hard-wired zero, so neither the register file nor a
            // writeback aimed at x0 may leak a value into the operand.
            assign byp[gi] = (rs_addr[gi] == '0) ? '0 :
                             (wb_wr_en_i && (wb_addr_i == rs_addr[gi])) ? wb_data_i :
                             rs_data[gi];
            assign dep[gi] = uses[gi] && (rs_addr[gi] == ex_rd_addr_i);
        end
    endgenerate

    assign byp_rs1_o = byp[0];
    assign byp_rs2_o = byp[1];

    assign hazard_o = id_valid_i && ex_valid_i && ex_is_load_i &&
                      (ex_rd_addr_i != '0) && (|dep);

endmodule

// File: rtl/id_ex_pipeline.sv
// ----------------------------------------------------------------------------
// id_ex_pipeline
// ID/EX pipeline register for the RV32I core. Captures decoded fields and
// bypass-corrected operands, inserts a single bubble on a load-use hazard,
// holds on EX_stall (refreshing parked operands from writeback) and kills
// the EX slot on Flush. Bubble_count saturates at all-ones.
//
// Ports
//   Clk, Reset_n               clock, asynchronous active-low reset
//   ID_*                       decoded instruction from the decode stage
//   Rs1_data, Rs2_data         register file read data
//   WB_rd_wr_en/addr/wr_data   writeback port
//   EX_stall, Flush            downstream hold / branch redirect
//   ID_stall                   combinational hold request to IF/ID
//   EX_*                       registered instruction presented to execute
//   Bubble_count               saturating count of load-use bubbles
//
// The payload struct is sized from RV32I_definitions; the parameters below
// must be left at the package values.
// ----------------------------------------------------------------------------
module id_ex_pipeline
    import RV32I_definitions::*;
#(
    parameter int REG_DATA_WIDTH     = RV32I_definitions::REG_DATA_WIDTH,
    parameter int REGFILE_ADDR_WIDTH = RV32I_definitions::REGFILE_ADDR_WIDTH,
    parameter int CTRL_WIDTH         = RV32I_definitions::CTRL_WIDTH
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          ID_valid,
    input  logic [REG_DATA_WIDTH-1:0]     ID_pc,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rs2_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rd_addr,
    input  logic                          ID_uses_rs1,
    input  logic                          ID_uses_rs2,
    input  logic                          ID_is_load,
    input  logic [REG_DATA_WIDTH-1:0]     ID_imm,
    input  logic [CTRL_WIDTH-1:0]         ID_ctrl,
    input  logic [REG_DATA_WIDTH-1:0]     Rs1_data,
    input  logic [REG_DATA_WIDTH-1:0]     Rs2_data,
    input  logic                          WB_rd_wr_en,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WB_rd_addr,
    input  logic [REG_DATA_WIDTH-1:0]     WB_rd_wr_data,
    input  logic                          EX_stall,
    input  logic                          Flush,
    output logic                          ID_stall,
    output logic                          EX_valid,
    output logic [REG_DATA_WIDTH-1:0]     EX_pc,
    output logic [REG_DATA_WIDTH-1:0]     EX_imm,
    output logic [REGFILE_ADDR_WIDTH-1:0] EX_rs1_addr,
    output logic [REGFILE_ADDR_WIDTH-1:0] EX_rs2_addr,
    output logic [REGFILE_ADDR_WIDTH-1:0] EX_rd_addr,
    output logic [REG_DATA_WIDTH-1:0]     EX_rs1_data,
    output logic [REG_DATA_WIDTH-1:0]     EX_rs2_data,
    output logic                          EX_is_load,
    output logic [CTRL_WIDTH-1:0]         EX_ctrl,
    output logic [15:0]                   Bubble_count
);

    id_ex_payload_t              payload_q, payload_d, id_payload;
    logic                        valid_q, valid_d;
    logic [REG_DATA_WIDTH-1:0]   rs1_data_q, rs1_data_d;
    logic [REG_DATA_WIDTH-1:0]   rs2_data_q, rs2_data_d;
    logic [15:0]                 bubble_count_q, bubble_count_d;
    logic                        hazard;
    logic [REG_DATA_WIDTH-1:0]   byp_rs1, byp_rs2;

    id_hazard_unit #(
        .DW (REG_DATA_WIDTH),
        .AW (REGFILE_ADDR_WIDTH)
    ) u_hazard (
        .id_valid_i   (ID_valid),
        .rs1_addr_i   (ID_rs1_addr),
        .rs2_addr_i   (ID_rs2_addr),
        .uses_rs1_i   (ID_uses_rs1),
        .uses_rs2_i   (ID_uses_rs2),
        .rs1_data_i   (Rs1_data),
        .rs2_data_i   (Rs2_data),
        .ex_valid_i   (valid_q),
        .ex_is_load_i (payload_q.is_load),
        .ex_rd_addr_i (payload_q.rd_addr),
        .wb_wr_en_i   (WB_rd_wr_en),
        .wb_addr_i    (WB_rd_addr),
        .wb_data_i    (WB_rd_wr_data),
        .hazard_o     (hazard),
        .byp_rs1_o    (byp_rs1),
        .byp_rs2_o    (byp_rs2)
    );

    always_comb begin
        id_payload          = '0;
        id_payload.pc       = ID_pc;
        id_payload.rs1_addr = ID_rs1_addr;
        id_payload.rs2_addr = ID_rs2_addr;
        id_payload.rd_addr  = ID_rd_addr;
        id_payload.imm      = ID_imm;
        id_payload.ctrl     = ID_ctrl;
        id_payload.is_load  = ID_is_load;
    end

    // IF is redirecting during Flush, so holding it would be pointless.
    assign ID_stall = !Flush && (EX_stall || hazard);

    always_comb begin
        payload_d      = payload_q;
        valid_d        = valid_q;
        rs1_data_d     = rs1_data_q;
        rs2_data_d     = rs2_data_q;
        bubble_count_d = bubble_count_q;
        if (Flush) begin
            valid_d = 1'b0;
        end else if (EX_stall) begin
            // A parked operand would go stale if its producer retires while
            // EX is frozen; pick the writeback value up in place.
            if (WB_rd_wr_en && (payload_q.rs1_addr != '0) && (WB_rd_addr == payload_q.rs1_addr))
                rs1_data_d = WB_rd_wr_data;
            if (WB_rd_wr_en && (payload_q.rs2_addr != '0) && (WB_rd_addr == payload_q.rs2_addr))
                rs2_data_d = WB_rd_wr_data;
        end else if (hazard) begin
            valid_d = 1'b0;
            if (bubble_count_q != 16'hFFFF)
                bubble_count_d = bubble_count_q + 16'd1;
        end else begin
            payload_d  = id_payload;
            valid_d    = ID_valid;
            rs1_data_d = byp_rs1;
            rs2_data_d = byp_rs2;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            payload_q      <= '0;
            valid_q        <= 1'b0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            bubble_count_q <= '0;
        end else begin
            payload_q      <= payload_d;
            valid_q        <= valid_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign EX_valid     = valid_q;
    assign EX_pc        = payload_q.pc;
    assign EX_imm       = payload_q.imm;
    assign EX_rs1_addr  = payload_q.rs1_addr;
    assign EX_rs2_addr  = payload_q.rs2_addr;
    assign EX_rd_addr   = payload_q.rd_addr;
    assign EX_is_load   = payload_q.is_load;
    assign EX_ctrl      = payload_q.ctrl;
    assign EX_rs1_data  = rs1_data_q;
    assign EX_rs2_data  = rs2_data_q;
    assign Bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_pipeline.sv
module tb_id_ex_pipeline;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        ID_valid;
    logic [31:0] ID_pc;
    logic [4:0]  ID_rs1_addr, ID_rs2_addr, ID_rd_addr;
    logic        ID_uses_rs1, ID_uses_rs2, ID_is_load;
    logic [31:0] ID_imm;
    logic [15:0] ID_ctrl;
    logic [31:0] Rs1_data, Rs2_data;
    logic        WB_rd_wr_en;
    logic [4:0]  WB_rd_addr;
    logic [31:0] WB_rd_wr_data;
    logic        EX_stall, Flush;
    logic        ID_stall, EX_valid, EX_is_load;
    logic [31:0] EX_pc, EX_imm, EX_rs1_data, EX_rs2_data;
    logic [4:0]  EX_rs1_addr, EX_rs2_addr, EX_rd_addr;
    logic [15:0] EX_ctrl, Bubble_count;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    id_ex_pipeline dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ID_valid(ID_valid), .ID_pc(ID_pc),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr), .ID_rd_addr(ID_rd_addr),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .ID_is_load(ID_is_load),
        .ID_imm(ID_imm), .ID_ctrl(ID_ctrl),
        .Rs1_data(Rs1_data), .Rs2_data(Rs2_data),
        .WB_rd_wr_en(WB_rd_wr_en), .WB_rd_addr(WB_rd_addr), .WB_rd_wr_data(WB_rd_wr_data),
        .EX_stall(EX_stall), .Flush(Flush), .ID_stall(ID_stall),
        .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_imm(EX_imm),
        .EX_rs1_addr(EX_rs1_addr), .EX_rs2_addr(EX_rs2_addr), .EX_rd_addr(EX_rd_addr),
        .EX_rs1_data(EX_rs1_data), .EX_rs2_data(EX_rs2_data),
        .EX_is_load(EX_is_load), .EX_ctrl(EX_ctrl), .Bubble_count(Bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2, input logic ld,
                          input logic [31:0] d1, input logic [31:0] d2);
        ID_valid = 1'b1; ID_pc = pc; ID_rs1_addr = rs1; ID_rs2_addr = rs2; ID_rd_addr = rd;
        ID_uses_rs1 = u1; ID_uses_rs2 = u2; ID_is_load = ld; Rs1_data = d1; Rs2_data = d2;
    endtask

    initial begin
        Reset_n = 1'b0; ID_valid = 0; ID_pc = 0; ID_rs1_addr = 0; ID_rs2_addr = 0;
        ID_rd_addr = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0; ID_is_load = 0; ID_imm = 0;
        ID_ctrl = 0; Rs1_data = 0; Rs2_data = 0; WB_rd_wr_en = 0; WB_rd_addr = 0;
        WB_rd_wr_data = 0; EX_stall = 0; Flush = 0;

        // Reset state
        #12;
        chk("rst_valid", 32'(EX_valid), 0);
        chk("rst_pc", EX_pc, 0);
        chk("rst_bubbles", 32'(Bubble_count), 0);
        Reset_n = 1'b1;

        // Plain advance: addi x6, x5, 1
        set_id(32'h100, 5'd5, 5'd0, 5'd6, 1, 0, 0, 32'h10, 32'h0);
        ID_imm = 32'h1; ID_ctrl = 16'h00A5;
        step();
        chk("adv_valid", 32'(EX_valid), 1);
        chk("adv_rs1", EX_rs1_data, 32'h10);
        chk("adv_pc", EX_pc, 32'h100);
        chk("adv_rd", 32'(EX_rd_addr), 6);
        chk("adv_ctrl", 32'(EX_ctrl), 32'h00A5);
        chk("adv_imm", EX_imm, 1);

        // WB bypass on x7; rs2=x0 must capture 0 despite nonzero read data
        set_id(32'h104, 5'd7, 5'd0, 5'd8, 1, 1, 0, 32'h0, 32'h1234);
        WB_rd_wr_en = 1; WB_rd_addr = 5'd7; WB_rd_wr_data = 32'hDEADBEEF;
        step();
        chk("byp_rs1", EX_rs1_data, 32'hDEADBEEF);
        chk("byp_rs2_x0", EX_rs2_data, 0);

        // Writeback to x0 never bypasses
        set_id(32'h108, 5'd0, 5'd0, 5'd9, 1, 0, 0, 32'h99, 32'h0);
        WB_rd_addr = 5'd0;
        step();
        chk("byp_x0", EX_rs1_data, 0);
        WB_rd_wr_en = 0;

        // Load-use: lw x3 then add x8, x2, x3
        set_id(32'h10C, 5'd1, 5'd0, 5'd3, 1, 0, 1, 32'h2000, 32'h0);
        step();
        chk("lw_is_load", 32'(EX_is_load), 1);
        set_id(32'h110, 5'd2, 5'd3, 5'd8, 1, 1, 0, 32'h5, 32'h7);
        #1;
        chk("lu_id_stall", 32'(ID_stall), 1);
        step();
        chk("lu_bubble", 32'(EX_valid), 0);
        chk("lu_count", 32'(Bubble_count), 1);
        chk("lu_stall_clr", 32'(ID_stall), 0);
        WB_rd_wr_en = 1; WB_rd_addr = 5'd3; WB_rd_wr_data = 32'h77;
        step();
        WB_rd_wr_en = 0;
        chk("lu_adv_valid", 32'(EX_valid), 1);
        chk("lu_adv_pc", EX_pc, 32'h110);
        chk("lu_adv_rs2", EX_rs2_data, 32'h77);
        chk("lu_adv_rs1", EX_rs1_data, 32'h5);

        // Stall with parked operand: add x10, x4, x9
        set_id(32'h114, 5'd4, 5'd9, 5'd10, 1, 1, 0, 32'h11, 32'h22);
        step();
        chk("park_rs1_init", EX_rs1_data, 32'h11);
        EX_stall = 1;
        set_id(32'h118, 5'd1, 5'd2, 5'd11, 1, 1, 0, 32'hAA, 32'hBB);
        #1;
        chk("park_stall1", 32'(ID_stall), 1);
        step();
        chk("park_pc1", EX_pc, 32'h114);
        chk("park_rs1_1", EX_rs1_data, 32'h11);
        WB_rd_wr_en = 1; WB_rd_addr = 5'd4; WB_rd_wr_data = 32'h55;
        #1;
        chk("park_stall2", 32'(ID_stall), 1);
        step();
        WB_rd_wr_en = 0;
        chk("park_rs1_2", EX_rs1_data, 32'h55);
        chk("park_rs2_2", EX_rs2_data, 32'h22);
        chk("park_rd_2", 32'(EX_rd_addr), 10);
        chk("park_stall3", 32'(ID_stall), 1);
        step();
        chk("park_rs1_3", EX_rs1_data, 32'h55);
        chk("park_pc3", EX_pc, 32'h114);
        chk("park_valid3", 32'(EX_valid), 1);
        EX_stall = 0;

        // Flush beats stall and hazard
        set_id(32'h120, 5'd1, 5'd0, 5'd12, 1, 0, 1, 32'h0, 32'h0);
        step();
        set_id(32'h124, 5'd12, 5'd0, 5'd13, 1, 0, 0, 32'h0, 32'h0);
        EX_stall = 1; Flush = 1;
        #1;
        chk("fl_id_stall", 32'(ID_stall), 0);
        step();
        chk("fl_valid", 32'(EX_valid), 0);
        chk("fl_count", 32'(Bubble_count), 1);
        Flush = 0; EX_stall = 0;

        // Asynchronous reset while stalled
        set_id(32'h130, 5'd1, 5'd0, 5'd14, 1, 0, 0, 32'h33, 32'h0);
        step();
        EX_stall = 1;
        #1;
        chk("rs_pre_stall", 32'(ID_stall), 1);
        Reset_n = 0;
        #1;
        chk("rs_valid", 32'(EX_valid), 0);
        chk("rs_pc", EX_pc, 0);
        chk("rs_rs1", EX_rs1_data, 0);
        chk("rs_count", 32'(Bubble_count), 0);
        chk("rs_id_stall", 32'(ID_stall), 1);
        EX_stall = 0;
        #1;
        chk("rs_id_stall0", 32'(ID_stall), 0);
        Reset_n = 1;

        // Saturation: preload near the top, then produce bubbles
        force dut.bubble_count_q = 16'hFFFD;
        #1;
        release dut.bubble_count_q;
        #1;
        chk("sat_preload", 32'(Bubble_count), 32'hFFFD);
        for (int i = 0; i < 4; i++) begin
            set_id(32'h200 + 32'(i * 8), 5'd1, 5'd0, 5'd3, 1, 0, 1, 32'h0, 32'h0);
            step();
            set_id(32'h204 + 32'(i * 8), 5'd3, 5'd0, 5'd5, 1, 0, 0, 32'h0, 32'h0);
            step();
            chk("sat_bubble", 32'(EX_valid), 0);
            chk("sat_count", 32'(Bubble_count), (i == 0) ? 32'hFFFE : 32'hFFFF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_pipeline.md
# id_ex_pipeline

ID/EX pipeline register for the RV32I core. It sits directly downstream of the register file. It captures decoded fields and register operands at the end of decode and presents them to the execute stage. It also provides write-through bypass for same-cycle writeback writes, detects load-use hazards and inserts bubbles, and honours downstream stall and branch flush.

## Interface
Parameters:
- REG_DATA_WIDTH, 32, operand/PC/immediate width
- REGFILE_ADDR_WIDTH, 5, register address width
- CTRL_WIDTH, 16, width of the opaque decoded control bundle

Ports:
- Clk  in  1  core clock, all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ID_valid  in  1  decode holds a valid instruction
- ID_pc  in  REG_DATA_WIDTH  instruction PC
- ID_rs1_addr, ID_rs2_addr, ID_rd_addr  in  REGFILE_ADDR_WIDTH  register specifiers
- ID_uses_rs1, ID_uses_rs2  in  1  instruction actually reads rs1/rs2
- ID_is_load  in  1  instruction is a load
- ID_imm  in  REG_DATA_WIDTH  decoded immediate
- ID_ctrl  in  CTRL_WIDTH  decoded control bundle, passed through untouched
- Rs1_data, Rs2_data  in  REG_DATA_WIDTH  register file read data (combinational read)
- WB_rd_wr_en  in  1  writeback write enable, the same signal driven to the register file
- WB_rd_addr  in  REGFILE_ADDR_WIDTH  writeback destination
- WB_rd_wr_data  in  REG_DATA_WIDTH  writeback data
- EX_stall  in  1  execute cannot accept; hold contents
- Flush  in  1  taken branch/jump redirect; kill the instruction in ID and the instruction in EX
- ID_stall  out  1  combinational; IF/ID must hold its contents
- EX_valid  out  1  EX holds a real instruction
- EX_pc, EX_imm  out  REG_DATA_WIDTH  registered copies
- EX_rs1_addr, EX_rs2_addr, EX_rd_addr  out  REGFILE_ADDR_WIDTH  registered copies
- EX_rs1_data, EX_rs2_data  out  REG_DATA_WIDTH  registered operands, bypass-corrected
- EX_is_load  out  1  registered copy
- EX_ctrl  out  CTRL_WIDTH  registered copy
- Bubble_count  out  16  saturating count of load-use bubbles inserted

## Operation
- **Reset:** all registered outputs go to 0 immediately on Reset_n low, including EX_valid and Bubble_count.
- **Bypass.** byp_rsN selects WB_rd_wr_data when WB_rd_wr_en=1, WB_rd_addr=ID_rsN_addr and ID_rsN_addr≠0; otherwise it selects RsN_data. Operand address 0 always captures 0.
- **Load-use hazard:** hazard = ID_valid & EX_valid & EX_is_load & EX_rd_addr≠0 & ((ID_uses_rs1 & ID_rs1_addr=EX_rd_addr) | (ID_uses_rs2 & ID_rs2_addr=EX_rd_addr)).
- **Per-edge action, in priority order:**
  1. Flush: EX_valid←0. Other EX fields don't-care; they may load.
  2. EX_stall: hold every EX register except the held operands. If WB_rd_wr_en=1 and WB_rd_addr equals the EX_rsN_addr (≠0), then EX_rsN_data←WB_rd_wr_data. This keeps a parked operand from going stale.
  3. hazard: EX_valid←0 (bubble), and Bubble_count←Bubble_count+1, saturating at 0xFFFF.
  4. Otherwise: load all EX fields from ID, with EX_valid←ID_valid and operands from byp_rsN.
- **ID_stall** = ~Flush & (EX_stall | hazard). It is never asserted during Flush, because IF is redirecting.
- EX_ctrl and the immediate are never interpreted inside the block.

## Timing
- Latency is 1 cycle, ID to EX.
- Throughput is 1 instruction per cycle absent stalls.
- A load-use hazard costs exactly one bubble. On the next edge EX holds the bubble, so the hazard clears and the dependent instruction advances.
- Bypass and hazard paths are combinational from ID inputs and WB inputs to ID_stall and to the EX register D inputs.
- Flush takes effect at the same edge it is sampled. The EX_valid=0 bubble is visible the following cycle.
- Reset asserted mid-stall clears all state asynchronously. ID_stall then follows its equation with EX_valid=0, so it is only asserted when EX_stall=1.

## Structure
- Put CTRL_WIDTH and a packed typedef for the ID→EX payload in the shared RV32I_definitions package. The payload covers pc, addrs, imm, ctrl and is_load.
- Use one sub-module, id_hazard_unit. It is purely combinational and computes hazard and byp_rs1/byp_rs2 from its inputs.
- The top level holds the EX registers, the priority logic and Bubble_count.

## Test plan
- **Plain advance.** ID addi with rs1=x5, Rs1_data=0x10, no stall. Next cycle: EX_valid=1, EX_rs1_data=0x10, EX_pc matches ID_pc.
- **WB bypass.** ID reads x7 while WB writes x7=0xDEAD_BEEF and Rs1_data=0. EX_rs1_data=0xDEADBEEF. Repeat with x0: EX_rs1_data=0.
- **Load-use.** EX holds lw to x3, and ID add uses rs2=x3. Required: ID_stall=1 for one cycle, EX_valid=0 next cycle, Bubble_count=1. The add enters EX on the following edge.
- **Stall with parked operand.** EX holds add with rs1=x4, and EX_stall=1 for 3 cycles. WB writes x4=0x55 during the stall. Required: EX fields are unchanged except EX_rs1_data=0x55, and ID_stall=1 throughout.
- **Flush priority.** Flush=1 together with EX_stall=1 and hazard=1. Required: next cycle EX_valid=0, ID_stall=0 during Flush, Bubble_count unchanged.
- **Reset and saturation.** Asynchronous Reset_n low mid-stall clears all outputs to 0 before the next edge. Forcing 65 536 bubbles gives Bubble_count=0xFFFF, holding there.
